// File: rtl/mem_readback.sv
// Read-side sweep master for a registered-read BRAM: walks addresses 0..DEPTH_MEM-1,
// buffers returned words in a small FIFO and streams them out on valid/ready with a checksum.
module mem_readback #(
    parameter int WID_MEM   = 3,
    parameter int DEPTH_MEM = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] m_data,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic [31:0]        checksum
);
    localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_addr;
    logic [31:0]        r_raddr;
    logic               r_inflight;
    logic               r_inflight_last;
    logic               r_slot_ok;
    logic [WID_MEM-1:0] r_fifo_data [4];
    logic [3:0]         r_fifo_last;
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_count;
    logic               r_done;
    logic [31:0]        r_checksum;

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_addr_last;
    logic [2:0]         w_occupancy;

    // Issue permission is taken from last cycle's occupancy, so a read that is still
    // in flight when the FIFO holds three words can land in the fourth slot.
    assign w_issue     = (r_state == RUN) && r_slot_ok;
    assign w_addr_last = (r_addr == AW'(DEPTH_MEM - 1));
    assign w_push      = r_inflight;
    assign w_pop       = m_valid && m_ready;
    assign w_occupancy = r_count + {2'b00, r_inflight};

    assign raddr    = w_issue ? 32'(r_addr) : r_raddr;
    assign m_valid  = (r_count != 3'd0);
    assign m_data   = m_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign m_last   = m_valid && r_fifo_last[r_rd_ptr];
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign checksum = r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_raddr         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_slot_ok       <= 1'b0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_done          <= 1'b0;
            r_checksum      <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state         <= IDLE;
                r_wr_ptr        <= '0;
                r_rd_ptr        <= '0;
                r_count         <= '0;
                r_inflight      <= 1'b0;
                r_inflight_last <= 1'b0;
                r_slot_ok       <= 1'b1;
            end else if (r_state == IDLE) begin
                if (start) begin
                    r_state         <= RUN;
                    r_addr          <= '0;
                    r_wr_ptr        <= '0;
                    r_rd_ptr        <= '0;
                    r_count         <= '0;
                    r_inflight      <= 1'b0;
                    r_inflight_last <= 1'b0;
                    r_checksum      <= '0;
                    r_slot_ok       <= 1'b1;
                end
            end else begin
                r_slot_ok       <= (w_occupancy <= 3'd2);
                r_inflight      <= w_issue;
                r_inflight_last <= w_issue && w_addr_last;

                // The counter stops on the final address rather than wrapping.
                if (w_issue) begin
                    r_raddr <= 32'(r_addr);
                    if (w_addr_last) begin
                        r_state <= DRAIN;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end

                if (w_push) begin
                    r_fifo_data[r_wr_ptr] <= mem_dout;
                    r_fifo_last[r_wr_ptr] <= r_inflight_last;
                    r_wr_ptr              <= r_wr_ptr + 2'd1;
                end

                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + 2'd1;
                    r_checksum <= r_checksum + 32'(m_data);
                    if (m_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end

                if (w_push && !w_pop) begin
                    r_count <= r_count + 3'd1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: a 4096-word sweep DUT checked through a beat scoreboard,
// plus a two-word instance for the minimum-depth timing case.
module tb_mem_readback;
    localparam int DEPTH_A = 4096;

    typedef struct {
        logic [2:0] data;
        logic       last;
    } beat_t;

    logic        clk;
    logic        reset;

    logic        startA, abortA, readyA;
    logic [31:0] raddrA;
    logic [2:0]  memDoutA;
    logic        validA, lastA, busyA, doneA;
    logic [2:0]  dataA;
    logic [31:0] checksumA;

    logic        startB, abortB, readyB;
    logic [31:0] raddrB;
    logic [2:0]  memDoutB;
    logic        validB, lastB, busyB, doneB;
    logic [2:0]  dataB;
    logic [31:0] checksumB;

    logic [2:0]  memA [DEPTH_A];
    logic [2:0]  memB [2];

    beat_t       expQ [$];
    beat_t       monBeat;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          tStart = 0;
    int          beatCount = 0;
    int          doneCount = 0;
    int          doneCyc = -1;
    int          firstValidCyc = -1;
    int          lastHsCyc = -1;
    int          dc0 = 0;
    logic [31:0] modelSum = 0;
    logic [31:0] maxRaddr = 0;
    logic        prevStall = 1'b0;
    logic [3:0]  prevWord = 4'd0;

    mem_readback #(.WID_MEM(3), .DEPTH_MEM(DEPTH_A)) dutA (
        .clk(clk), .reset(reset), .start(startA), .abort(abortA), .raddr(raddrA),
        .mem_dout(memDoutA), .m_valid(validA), .m_ready(readyA), .m_data(dataA),
        .m_last(lastA), .busy(busyA), .done(doneA), .checksum(checksumA)
    );

    mem_readback #(.WID_MEM(3), .DEPTH_MEM(2)) dutB (
        .clk(clk), .reset(reset), .start(startB), .abort(abortB), .raddr(raddrB),
        .mem_dout(memDoutB), .m_valid(validB), .m_ready(readyB), .m_data(dataB),
        .m_last(lastB), .busy(busyB), .done(doneB), .checksum(checksumB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read memory stubs standing in for the BRAM.
    initial begin
        for (int i = 0; i < DEPTH_A; i++) memA[i] = 3'(i % 8);
        memB[0] = 3'd5;
        memB[1] = 3'd6;
    end
    always @(posedge clk) memDoutA <= memA[raddrA[11:0]];
    always @(posedge clk) memDoutB <= memB[raddrB[0]];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep on dutA and preloads the scoreboard with the expected beats.
    task automatic applyStimulus();
        beat_t b;
        expQ.delete();
        for (int i = 0; i < DEPTH_A; i++) begin
            b.data = 3'(i % 8);
            b.last = (i == DEPTH_A - 1);
            expQ.push_back(b);
        end
        modelSum      = 0;
        beatCount     = 0;
        firstValidCyc = -1;
        lastHsCyc     = -1;
        startA        = 1'b1;
        tStart        = cyc;
        tick();
        startA   = 1'b0;
        maxRaddr = 0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && doneCount == dc0; i++) tick();
        checkOutput("done_seen", doneCount - dc0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_raddr"}, raddrA, 0);
        checkOutput({tag, "_busy"}, 32'(busyA), 0);
        checkOutput({tag, "_done"}, 32'(doneA), 0);
        checkOutput({tag, "_valid"}, 32'(validA), 0);
        checkOutput({tag, "_last"}, 32'(lastA), 0);
        checkOutput({tag, "_data"}, 32'(dataA), 0);
        checkOutput({tag, "_checksum"}, checksumA, 0);
    endtask

    // Scoreboard side: pops one expected beat per accepted handshake.
    always @(negedge clk) begin
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (raddrA > maxRaddr) maxRaddr = raddrA;
            if (doneA) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (validA && firstValidCyc < 0) firstValidCyc = cyc;
            if (prevStall) checkOutput("stall_hold", 32'({validA, lastA, dataA}), 32'({1'b1, prevWord}));
            if (validA && readyA && !abortA) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", 1, 0);
                end else begin
                    monBeat = expQ.pop_front();
                    checkOutput("beat_data", 32'(dataA), 32'(monBeat.data));
                    checkOutput("beat_last", 32'(lastA), 32'(monBeat.last));
                    modelSum = modelSum + 32'(monBeat.data);
                end
                beatCount++;
                lastHsCyc = cyc;
            end
            prevStall = validA && !readyA && !abortA;
            prevWord  = {lastA, dataA};
        end
    end

    initial begin
        reset  = 1'b1;
        startA = 1'b0; abortA = 1'b0; readyA = 1'b1;
        startB = 1'b0; abortB = 1'b0; readyB = 1'b1;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        // Two-word instance: beats at T+3 and T+4, done at T+5.
        startB = 1'b1;
        tick();
        startB = 1'b0;
        tick(); tick();
        checkOutput("b_valid0", 32'(validB), 1);
        checkOutput("b_data0", 32'(dataB), 5);
        checkOutput("b_last0", 32'(lastB), 0);
        tick();
        checkOutput("b_data1", 32'(dataB), 6);
        checkOutput("b_last1", 32'(lastB), 1);
        checkOutput("b_done_early", 32'(doneB), 0);
        tick();
        checkOutput("b_done", 32'(doneB), 1);
        checkOutput("b_checksum", checksumB, 11);
        checkOutput("b_busy", 32'(busyB), 0);
        tick();
        checkOutput("b_done_pulse", 32'(doneB), 0);

        // Full sweep with m_ready held high.
        dc0 = doneCount;
        applyStimulus();
        waitDone(6000);
        checkOutput("s1_first_valid", firstValidCyc, tStart + 3);
        checkOutput("s1_last_hs", lastHsCyc, tStart + 2 + DEPTH_A);
        checkOutput("s1_done_cyc", doneCyc, tStart + 3 + DEPTH_A);
        checkOutput("s1_beats", beatCount, DEPTH_A);
        checkOutput("s1_checksum", checksumA, 14336);
        checkOutput("s1_model_sum", checksumA, modelSum);
        checkOutput("s1_queue_left", expQ.size(), 0);
        repeat (3) tick();
        checkOutput("s1_done_once", doneCount - dc0, 1);
        checkOutput("s1_checksum_hold", checksumA, 14336);

        // Random 30% ready.
        dc0 = doneCount;
        applyStimulus();
        for (int i = 0; i < 30000 && doneCount == dc0; i++) begin
            readyA = ($urandom_range(0, 99) < 30);
            tick();
        end
        readyA = 1'b1;
        checkOutput("s2_done_seen", doneCount - dc0, 1);
        checkOutput("s2_beats", beatCount, DEPTH_A);
        checkOutput("s2_checksum", checksumA, 14336);
        checkOutput("s2_max_raddr", maxRaddr, DEPTH_A - 1);

        // Consumer stalled for 20 cycles after start.
        readyA = 1'b0;
        dc0 = doneCount;
        applyStimulus();
        repeat (20) tick();
        checkOutput("stall_raddr", raddrA, 3);
        checkOutput("stall_max_raddr", maxRaddr, 3);
        checkOutput("stall_valid", 32'(validA), 1);
        checkOutput("stall_data", 32'(dataA), 0);
        checkOutput("stall_beats", beatCount, 0);
        readyA = 1'b1;
        waitDone(6000);
        checkOutput("stall_total_beats", beatCount, DEPTH_A);
        checkOutput("stall_checksum", checksumA, 14336);

        // Abort while beat 100 is on the output.
        dc0 = doneCount;
        applyStimulus();
        for (int i = 0; i < 1000 && beatCount < 100; i++) tick();
        checkOutput("abort_reach", beatCount, 100);
        checkOutput("abort_beat_data", 32'(dataA), 4);
        abortA = 1'b1;
        tick();
        abortA = 1'b0;
        checkOutput("abort_busy", 32'(busyA), 0);
        checkOutput("abort_valid", 32'(validA), 0);
        checkOutput("abort_checksum", checksumA, 342);
        checkOutput("abort_model_sum", checksumA, modelSum);
        repeat (10) tick();
        checkOutput("abort_no_done", doneCount - dc0, 0);
        checkOutput("abort_checksum_hold", checksumA, 342);

        // Fresh sweep, with a start pulse injected mid-sweep that must be ignored.
        dc0 = doneCount;
        applyStimulus();
        for (int i = 0; i < 1000 && beatCount < 500; i++) tick();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waitDone(6000);
        checkOutput("restart_beats", beatCount, DEPTH_A);
        checkOutput("restart_checksum", checksumA, 14336);
        checkOutput("restart_last_hs", lastHsCyc, tStart + 2 + DEPTH_A);
        repeat (3) tick();
        checkOutput("restart_done_once", doneCount - dc0, 1);

        // Reset pulsed mid-sweep.
        applyStimulus();
        repeat (50) tick();
        reset = 1'b1;
        tick();
        checkResetValues("midreset");
        reset = 1'b0;
        dc0 = doneCount;
        repeat (10) tick();
        checkOutput("midreset_no_done", doneCount - dc0, 0);
        checkOutput("midreset_busy", 32'(busyA), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_readback.md
# mem_readback

Sequential read-side master for the single-port-read BRAM `memory` block. On a start pulse it sweeps read addresses 0..DEPTH_MEM-1, absorbs the memory's one-cycle registered read latency, and streams every word out on a valid/ready interface with a running checksum. It sits between the BRAM's `raddr`/`dout` pins and any downstream consumer, for example a UART dumper or a compare engine, and is used to read back memory contents after bitstream reinitialisation.

## Interface
- WID_MEM, 3, data width; must match the attached memory.
- DEPTH_MEM, 4096, number of words swept; ≥ 2.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a sweep; ignored unless idle.
- abort  in  1  synchronous cancel of the sweep in progress.
- raddr  out  32  read address to memory; zero-extended counter.
- mem_dout  in  WID_MEM  memory `dout`.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  WID_MEM  output word.
- m_last  out  1  high with the word read from address DEPTH_MEM-1.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.
- checksum  out  32  sum modulo 2^32 of accepted words, each zero-extended.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN on start. This clears the address counter, FIFO, checksum and in-flight flag.
  - RUN to DRAIN when the read of address DEPTH_MEM-1 issues.
  - DRAIN to IDLE on the handshake of the m_last word. done pulses in the following cycle.
- Any non-IDLE state goes to IDLE on abort. abort flushes the FIFO and in-flight flag, holds checksum at its current value, and does not pulse done.
- abort has priority over every other event. start in the same cycle as abort is ignored.
- start while busy is ignored.
- Read issue: a read issues when the state is RUN and fifo_count + inflight ≤ 2.
  - On issue, raddr presents the current address during the issue cycle, the address counter increments, and inflight is set for the next cycle.
  - When no read issues, raddr holds its value.
- Capture: in the cycle after an issue (inflight=1), mem_dout is written into a 4-entry FIFO, together with a last flag equal to (address == DEPTH_MEM-1).
- Output: m_valid = FIFO not empty. m_data and m_last come from the FIFO head. A pop happens on m_valid & m_ready.
  - Simultaneous push and pop is legal and leaves fifo_count unchanged.
  - The issue rule guarantees that the FIFO never overflows.
- Checksum: on each handshake, checksum ← checksum + zero-extended m_data, wrapping modulo 2^32. It holds after done until the next start.
- busy = (state != IDLE).
- Outputs are stable while m_valid & !m_ready. m_data and m_last do not change until a pop.

## Timing
- Reset values:
  - state = IDLE.
  - raddr = 0, busy = 0, done = 0, m_valid = 0, m_last = 0, m_data = 0, checksum = 0.
  - FIFO empty, inflight = 0.
- start sampled high in cycle T gives:
  - busy = 1 and the first issue in cycle T+1, with raddr = 0.
  - mem_dout captured in T+2.
  - m_valid = 1 in T+3.
- With m_ready held at 1, one word is delivered per cycle with no bubbles after the first.
- With m_ready held at 1, the last handshake is at T+2+DEPTH_MEM and done pulses at T+3+DEPTH_MEM.
- When m_ready is deasserted, at most 4 words are buffered and issuing stalls. Issuing resumes in the cycle after fifo_count + inflight drops to ≤ 2.
- Reset asserted mid-sweep returns every output to its reset value on the next edge. No partial done is produced.
- The address counter never wraps. No read beyond DEPTH_MEM-1 is ever issued.

## Test plan
- Memory loaded with data[i] = i mod 8 (WID_MEM=3, DEPTH_MEM=4096); start with m_ready=1 -> 4096 beats with data 0,1,…,7 repeating, no gaps after the first beat. m_last is high only on beat 4095. checksum = 14336 (0x3800). done pulses once, 4099 cycles after start.
- Same load with m_ready toggled by a random 30% duty -> identical beat sequence and checksum. Data is stable while stalled. raddr never exceeds 4095.
- m_ready held at 0 after start for 20 cycles -> exactly 4 reads issued (raddr 0..3). m_valid stays high with m_data = data[0]. Release m_ready -> the stream continues in order from word 0.
- abort asserted at beat 100 -> next cycle busy=0 and m_valid=0. done never pulses. checksum is held. A later start gives a full, correct sweep with checksum recomputed from 0.
- reset pulsed mid-sweep -> all outputs at reset values next cycle. start during an active sweep -> ignored, and the sweep completes with the normal checksum.
- DEPTH_MEM=2, data {5,6}, m_ready=1 -> two beats: 5, then 6 with m_last. checksum = 11. done pulses at T+5.
